// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// State encoding, sequential step and default reset/trap vectors.
package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  localparam int          PC_STEP     = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect target (aligned or trapped), pc+step, or hold.
// In: i_pc, i_pc_plus_step, i_target, i_redirect, i_handshake.
// Out: o_pc_next (+ o_trap when PC_MISALIGN_TRAP_EN is defined).
module pc_next_sel
  import pc_fetch_seq_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [WIDTH-1:0] TRAP_PC = WIDTH'(DEF_TRAP_PC)
`endif
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_pc_plus_step,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_redirect,
  input  logic             i_handshake,
`ifdef PC_MISALIGN_TRAP_EN
  output logic             o_trap,
`endif
  output logic [WIDTH-1:0] o_pc_next
);

  logic [WIDTH-1:0] w_aligned;
  logic             w_mis;
  logic             w_sel_trap;
  logic             w_sel_tgt;
  logic             w_sel_inc;

  // Low two bits cleared on every load.
  assign w_aligned = i_target & ~WIDTH'(3);

`ifdef PC_MISALIGN_TRAP_EN
  assign w_mis  = |i_target[1:0];
  assign o_trap = w_sel_trap;
`else
  assign w_mis  = 1'b0;
`endif

  assign w_sel_trap = i_redirect & w_mis;
  assign w_sel_tgt  = i_redirect & ~w_mis;
  assign w_sel_inc  = i_handshake & ~i_redirect;

  always_comb begin
    o_pc_next = i_pc;
    unique case (1'b1)
`ifdef PC_MISALIGN_TRAP_EN
      w_sel_trap: o_pc_next = TRAP_PC;
`else
      w_sel_trap: o_pc_next = w_aligned;
`endif
      w_sel_tgt:  o_pc_next = w_aligned;
      w_sel_inc:  o_pc_next = i_pc_plus_step;
      default:    o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// PC register + IDLE/RUN/BUBBLE fetch sequencer with valid/ready and count.
// Ports: clk, reset, redirect, target, out_ready -> pc, pc_plus_step,
// out_valid, fetch_count (+ misalign when PC_MISALIGN_TRAP_EN is defined).
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int               STEP     = PC_STEP
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [WIDTH-1:0] TRAP_PC = WIDTH'(DEF_TRAP_PC)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             out_valid,
`ifdef PC_MISALIGN_TRAP_EN
  output logic             misalign,
`endif
  output logic [31:0]      fetch_count
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_valid;
  logic [31:0]      r_count;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_hs;
`ifdef PC_MISALIGN_TRAP_EN
  logic             w_trap;
  logic             r_mis;
`endif

  assign pc           = r_pc;
  assign pc_plus_step = r_pc + WIDTH'(STEP);
  assign out_valid    = r_valid;
  assign fetch_count  = r_count;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign     = r_mis;
`endif

  // Only a live RUN fetch accepted without a redirect advances.
  assign w_hs = (r_state == ST_RUN) & out_ready & ~redirect;

  pc_next_sel #(
    .WIDTH(WIDTH)
`ifdef PC_MISALIGN_TRAP_EN
    , .TRAP_PC(TRAP_PC)
`endif
  ) u_sel (
    .i_pc          (r_pc),
    .i_pc_plus_step(pc_plus_step),
    .i_target      (target),
    .i_redirect    (redirect),
    .i_handshake   (w_hs),
`ifdef PC_MISALIGN_TRAP_EN
    .o_trap        (w_trap),
`endif
    .o_pc_next     (w_pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_count <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      r_pc <= w_pc_next;
`ifdef PC_MISALIGN_TRAP_EN
      r_mis <= w_trap;
`endif
      unique case (r_state)
        ST_IDLE: begin
          r_state <= ST_RUN;
          r_valid <= 1'b1;
        end
        ST_RUN: begin
          if (redirect) begin
            r_state <= ST_BUBBLE;
            r_valid <= 1'b0;
          end else if (out_ready) begin
            r_count <= r_count + 32'd1;
          end
        end
        ST_BUBBLE: begin
          if (!redirect) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Self-checking bench for pc_fetch_seq: directed plan plus random traffic
// compared every cycle against a behavioural model.
module tb_pc_fetch_seq;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] target;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        out_valid;
  logic [31:0] fetch_count;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int vectors;
  int miscompares;

  pc_fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .target      (target),
    .out_ready   (out_ready),
    .pc          (pc),
    .pc_plus_step(pc_plus_step),
    .out_valid   (out_valid),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "fresh" = first cycle after reset, no fetch yet.
  bit          m_known;
  bit          m_fresh;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          m_mis;

  always @(posedge clk) begin
    logic [31:0] dest;
    bit          bad;
    bad  = (target % 4) != 0;
    dest = target - (target % 4);
`ifdef PC_MISALIGN_TRAP_EN
    if (bad) dest = 32'h100;
`endif
    if (reset) begin
      m_known = 1;
      m_fresh = 1;
      m_valid = 0;
      m_pc    = 32'h0;
      m_count = 0;
      m_mis   = 0;
    end else if (m_known) begin
      m_mis = redirect && bad;
      if (m_fresh) begin
        if (redirect) m_pc = dest;
        m_fresh = 0;
        m_valid = 1;
      end else if (redirect) begin
        m_pc    = dest;
        m_valid = 0;
      end else if (m_valid) begin
        if (out_ready) begin
          m_pc    = m_pc + 4;
          m_count = m_count + 1;
        end
      end else begin
        m_valid = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("pc_plus_step", pc_plus_step, m_pc + 32'd4);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("fetch_count", fetch_count, m_count);
`ifdef PC_MISALIGN_TRAP_EN
      chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
`endif
    end
  end

  task automatic cyc(input bit r, input bit rd, input logic [31:0] tg,
                     input bit rdy);
    reset     = r;
    redirect  = rd;
    target    = tg;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic pin(input string nm, input logic [31:0] epc,
                     input bit ev, input logic [31:0] ecnt);
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({nm, ".count"}, fetch_count, ecnt);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_known     = 0;
    cyc(1, 0, 0, 1);
    pin("reset", 32'h0, 0, 0);
    cyc(0, 0, 0, 1);
    pin("idle2run", 32'h0, 1, 0);
    cyc(0, 0, 0, 1);
    pin("run1", 32'h4, 1, 1);
    cyc(0, 0, 0, 1);
    pin("run2", 32'h8, 1, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      pin("stall", 32'h8, 1, 2);
    end
    cyc(0, 0, 0, 1);
    pin("unstall", 32'hC, 1, 3);
    cyc(0, 1, 32'h40, 1);
    pin("redir", 32'h40, 0, 3);
    cyc(0, 0, 0, 0);
    pin("redir_run", 32'h40, 1, 3);
    cyc(0, 1, 32'h40, 1);
    pin("b2b1", 32'h40, 0, 3);
    cyc(0, 1, 32'h80, 1);
    pin("b2b2", 32'h80, 0, 3);
    cyc(0, 0, 0, 0);
    pin("b2b_run", 32'h80, 1, 3);
    cyc(0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap.pps", pc_plus_step, 32'h0);
    cyc(0, 0, 0, 1);
    pin("wrap_run", 32'hFFFF_FFFC, 1, 3);
    cyc(0, 0, 0, 1);
    pin("wrap", 32'h0, 1, 4);
    cyc(0, 1, 32'h200, 1);
    pin("bub", 32'h200, 0, 4);
    cyc(1, 0, 0, 1);
    pin("rst_bub", 32'h0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h42, 0);
`ifdef PC_MISALIGN_TRAP_EN
    pin("mis", 32'h100, 0, 0);
    chk("mis.flag", {31'd0, misalign}, 32'd1);
    cyc(0, 0, 0, 0);
    chk("mis.drop", {31'd0, misalign}, 32'd0);
`else
    pin("mis", 32'h40, 0, 0);
    cyc(0, 0, 0, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = $urandom;
      if ($urandom_range(0, 3) == 0)
        tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 5) == 0,
          tg,
          $urandom_range(0, 2) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
